updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
//  Parametrised synchronous up/down modulo counter with load, clear and wrap/terminal-count flags.
//  Next-generation replacement for the fixed-width ripple-adder counter path.
//  Next-state arithmetic is a WIDTH-bit ripple chain of full-adder cells: add +1 or all-ones (-1).
//  Used as the count engine behind the display/timer front ends.
// PARAMETERS
//  WIDTH      4    counter width in bits (>=2)
//  MODULUS    16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0    value of count after rst/clr; must be < MODULUS
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous active-high reset
//  clr       in   1      synchronous clear to RESET_VAL, no flags
//  load      in   1      load load_val on next edge
//  load_val  in   WIDTH  parallel load value
//  en        in   1      count enable
//  up        in   1      1 = increment, 0 = decrement
//  count     out  WIDTH  registered count value
//  wrap      out  1      registered 1-cycle pulse: last edge wrapped (or saturated, see CONFIGURATION)
//  tc        out  1      combinational: count==MODULUS-1 && up, or count==0 && !up
//  ovf       out  1      sticky: set with any wrap pulse, cleared only by rst/clr
// BEHAVIOUR
//  - Reset: count=RESET_VAL, wrap=0, ovf=0. tc follows count/up combinationally.
//  - Per-edge priority: rst > clr > load > en. Exactly one action per edge.
//  - clr: count=RESET_VAL, wrap=0, ovf=0.
//  - load: count=load_val; if load_val>=MODULUS, count=MODULUS-1 (clamp). wrap=0; ovf unchanged.
//  - en=1 with up=1: count<MODULUS-1 -> count+1; count==MODULUS-1 -> 0, wrap=1, ovf=1.
//  - en=1 with up=0: count>0 -> count-1; count==0 -> MODULUS-1, wrap=1, ovf=1.
//  - en=0, no load/clr: count holds; wrap=0.
//  - Latency: count and wrap update on the same edge; wrap is high for exactly the one cycle
//    in which count shows the wrapped value.
//  - Direction may change on any cycle; the edge uses the up value sampled at that edge.
//  - load and en both high: load wins, no count step, no wrap.
//  - Arithmetic: ripple sum is WIDTH bits; carry-out is discarded. The modulo compare, not the
//    carry, detects wrap, so non-power-of-2 MODULUS is exact.
//  - tc is asserted whenever the next enabled step would wrap. It is valid while en=0.
//  - rst or clr asserted mid-sequence takes effect on that edge, regardless of other inputs.
// CONFIGURATION
//  UDC_SATURATE_EN defined:
//   - Boundary step holds count at MODULUS-1 (up) or 0 (down) instead of wrapping.
//   - wrap pulses 1 cycle (saturation hit); ovf sets. Repeated boundary steps re-pulse wrap each edge.
//  UDC_SATURATE_EN undefined: modulo wrap as in BEHAVIOUR; no saturation logic is built.
// TESTING (WIDTH=4, MODULUS=10, RESET_VAL=0, macro undefined unless stated)
//  1. rst=1 one edge with en=1,up=1 -> count=0, wrap=0, ovf=0. Then 9 enabled up edges
//     -> count=9, tc=1. 10th edge -> count=0, wrap=1 for one cycle, ovf=1.
//  2. From count=0, up=0, en=1 one edge -> count=9, wrap=1. Next edge -> count=8, wrap=0,
//     ovf remains 1.
//  3. load=1, load_val=12 -> count=9 (clamped). load=1, load_val=5, en=1 same edge -> count=5,
//     no step.
//  4. Count 3->4->5, then clr=1 with load=1 -> count=0, ovf=0. en=0 for 3 edges -> count holds,
//     wrap=0.
//  5. Toggle up every edge from count=5 with en=1 -> count 6,5,6,5. tc stays 0.
//  6. UDC_SATURATE_EN defined: at count=9, up, 3 edges -> count stays 9, wrap=1 each edge, ovf=1.
//     At 0, down -> holds 0.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, clear, wrap pulse and sticky overflow.
// Optional feature macro: UDC_SATURATE_EN (hold at the boundary instead of wrapping).
module updown_counter_mod #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_load_v;
    logic [WIDTH-1:0] w_bound_v;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_tc;

    // +1 or all-ones (-1); carry out of the top cell is dropped
    assign w_addend   = up ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_sum[i] = r_count[i] ^ w_addend[i] ^ w_carry[i];
        if (i < WIDTH - 1) begin : g_c
            assign w_carry[i+1] = (r_count[i] & w_addend[i])
                                | (w_carry[i] & (r_count[i] ^ w_addend[i]));
        end
    end

    assign w_at_top  = (r_count == MAXV);
    assign w_at_zero = (r_count == '0);
    assign w_tc      = up ? w_at_top : w_at_zero;
    assign w_load_v  = (load_val > MAXV) ? MAXV : load_val;

`ifdef UDC_SATURATE_EN
    assign w_bound_v = r_count;
`else
    assign w_bound_v = up ? '0 : MAXV;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= RSTV;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_v;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (w_tc) begin
                r_count <= w_bound_v;
                r_wrap  <= 1'b1;
                r_ovf   <= 1'b1;
            end else begin
                r_count <= w_sum;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    assign tc    = w_tc;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (WIDTH=4, MODULUS=10).
// Define UDC_SATURATE_EN for both files to exercise the saturating build.
module tb_updown_counter_mod;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] c;
        logic       w;
        logic       t;
        logic       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic [3:0] count;
    logic       wrap;
    logic       tc;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    updown_counter_mod #(
        .WIDTH(4),
        .MODULUS(10),
        .RESET_VAL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .load(load),
        .load_val(load_val),
        .en(en),
        .up(up),
        .count(count),
        .wrap(wrap),
        .tc(tc),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic cl, input logic ld, input logic [3:0] lv,
        input logic e, input logic u,
        input logic [3:0] c, input logic w, input logic t, input logic o
    );
        vec_t v;
        v.rst = r; v.clr = cl; v.load = ld; v.lv = lv; v.en = e; v.up = u;
        v.c = c; v.w = w; v.t = t; v.o = o;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        rst = v.rst; clr = v.clr; load = v.load;
        load_val = v.lv; en = v.en; up = v.up;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (count !== e.c || wrap !== e.w || tc !== e.t || ovf !== e.o) begin
                failures++;
                $display("FAIL %s: got count=%0d wrap=%b tc=%b ovf=%b, want count=%0d wrap=%b tc=%b ovf=%b",
                         name, count, wrap, tc, ovf, e.c, e.w, e.t, e.o);
            end
        end
    endtask

    initial begin
        // reset with en/up high, then 9 up steps to the terminal count
        tbl.push_back(mk(1,0,0,0, 1,1, 0,0,0,0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(0,0,0,0, 1,1, 4'(k),0,(k == 9),0));
        tbl.push_back(mk(0,0,0,0, 1,1, 0,1,0,1));
        // down-wrap from 0, then plain decrement with ovf sticky
        tbl.push_back(mk(0,0,0,0, 1,0, 9,1,0,1));
        tbl.push_back(mk(0,0,0,0, 1,0, 8,0,0,1));
        // load clamp, load beats en
        tbl.push_back(mk(0,0,1,12, 0,1, 9,0,1,1));
        tbl.push_back(mk(0,0,1,5,  1,1, 5,0,0,1));
        tbl.push_back(mk(0,0,1,10, 0,1, 9,0,1,1));
        tbl.push_back(mk(0,0,1,15, 0,0, 9,0,0,1));
        // 3->4->5 then clr with load, then hold with en=0 (tc valid while idle)
        tbl.push_back(mk(0,0,1,3, 0,1, 3,0,0,1));
        tbl.push_back(mk(0,0,0,0, 1,1, 4,0,0,1));
        tbl.push_back(mk(0,0,0,0, 1,1, 5,0,0,1));
        tbl.push_back(mk(0,1,1,7, 1,1, 0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,0,0, 0,0, 0,0,1,0));
        // direction toggling around 5
        tbl.push_back(mk(0,0,1,5, 0,1, 5,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,1, 6,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0, 5,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,1, 6,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0, 5,0,0,0));
        // rst overrides load and en
        tbl.push_back(mk(1,0,1,3, 1,1, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // repeated boundary steps upward from 9
        apply(mk(0,0,1,9, 0,1, 9,0,1,0), "up_load9");
`ifdef UDC_SATURATE_EN
        apply(mk(0,0,0,0, 1,1, 9,1,1,1), "sat_up1");
        apply(mk(0,0,0,0, 1,1, 9,1,1,1), "sat_up2");
        apply(mk(0,0,0,0, 1,1, 9,1,1,1), "sat_up3");
        apply(mk(0,0,0,0, 0,1, 9,0,1,1), "sat_idle");
        apply(mk(0,0,1,0, 0,0, 0,0,1,1), "dn_load0");
        apply(mk(0,0,0,0, 1,0, 0,1,1,1), "sat_dn1");
        apply(mk(0,0,0,0, 1,0, 0,1,1,1), "sat_dn2");
`else
        apply(mk(0,0,0,0, 1,1, 0,1,0,1), "wrap_up1");
        apply(mk(0,0,0,0, 1,1, 1,0,0,1), "wrap_up2");
        apply(mk(0,0,0,0, 1,1, 2,0,0,1), "wrap_up3");
        apply(mk(0,0,0,0, 0,1, 2,0,0,1), "wrap_idle");
        apply(mk(0,0,1,0, 0,0, 0,0,1,1), "dn_load0");
        apply(mk(0,0,0,0, 1,0, 9,1,0,1), "wrap_dn1");
        apply(mk(0,0,0,0, 1,0, 8,0,0,1), "wrap_dn2");
`endif
        // clr mid-count clears ovf regardless of en
        apply(mk(0,1,0,0, 1,0, 0,0,1,0), "clr_mid");

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
